apb_master: RTL and testbench

- Single-transfer APB3 initiator (requester).
- Takes one read or write command per valid/ready handshake on a local command port, drives the SETUP/ACCESS phases on the APB bus, and waits out slave wait states (pready low).
- Returns read data and error status on a held response port.
- Sits between a local controller/bench sequencer and APB register slaves on the same pclk domain.

---
 rtl/apb_master.sv | 150 +++++++++++++++
 tb/tb_apb_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// Single-transfer APB3 requester: one command per handshake, SETUP/ACCESS
// sequencing with wait states and optional timeout, held response port.
module apb_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB bus
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [DATA_W-1:0] prdata
);

    // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state, state_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [CNT_W-1:0]  cnt, cnt_d;

    assign cmd_ready = (state == IDLE) && !rsp_valid && presetn;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        psel_d        = psel;
        penable_d     = penable;
        paddr_d       = paddr;
        pwrite_d      = pwrite;
        pwdata_d      = pwdata;
        rsp_valid_d   = rsp_valid;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        rsp_rdata_d   = rsp_rdata;
        cnt_d         = cnt;

        if (rsp_valid && rsp_ready) begin
            rsp_valid_d   = 1'b0;
            rsp_err_d     = 1'b0;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
        end

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // Completion takes priority over a coincident timeout.
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_d;
            psel        <= psel_d;
            penable     <= penable_d;
            paddr       <= paddr_d;
            pwrite      <= pwrite_d;
            pwdata      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
            rsp_rdata   <= rsp_rdata_d;
            cnt         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: scripted APB slave plus a transaction-level model of
// expected response, latency and timeout behaviour.
module tb_apb_master;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite, psel, penable, pready, pslverr;
    logic [DATA_W-1:0] pwdata, prdata;

    int errors = 0;
    int checks = 0;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel),
        .penable(penable), .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    // One full transfer: slave holds pready low for 'waits' ACCESS cycles,
    // then the response is held for 'hold' cycles before being consumed.
    task automatic run_xfer(input string tag, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int waits, input bit err, input int hold);
        bit          timed_out;
        int          last;
        bit          exp_err;
        logic [31:0] exp_rd, exp_wd;
        timed_out = (TIMEOUT != 0) && (waits >= int'(TIMEOUT));
        last      = timed_out ? int'(TIMEOUT) - 1 : waits;
        exp_err   = timed_out || err;
        exp_rd    = (wr || timed_out) ? 32'h0 : rdata;
        exp_wd    = wr ? wdata : 32'h0;

        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready_idle got=%b exp=1", tag, cmd_ready); end
        @(posedge pclk); #1;
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = ~wr;
        checks++;
        if ({psel, penable} !== 2'b10) begin errors++; $display("FAIL %s setup_phase got=%b exp=10", tag, {psel, penable}); end
        checks++;
        if ({paddr, pwrite, pwdata} !== {addr, wr, exp_wd}) begin
            errors++; $display("FAIL %s setup_bus got=%h/%b/%h exp=%h/%b/%h", tag, paddr, pwrite, pwdata, addr, wr, exp_wd);
        end
        @(posedge pclk); #1;
        checks++;
        if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL %s access_phase got=%b exp=11", tag, {psel, penable}); end

        for (int k = 0; k <= last; k++) begin
            @(negedge pclk);
            pready  = (k == waits);
            pslverr = (k == waits) ? err : 1'($urandom);
            prdata  = (k == waits) ? rdata : $urandom;
            @(posedge pclk); #1;
            if (k < last) begin
                checks++;
                if ({psel, penable, rsp_valid} !== 3'b110) begin
                    errors++; $display("FAIL %s wait%0d_ctrl got=%b exp=110", tag, k, {psel, penable, rsp_valid});
                end
                checks++;
                if ({paddr, pwrite, pwdata} !== {addr, wr, exp_wd}) begin
                    errors++; $display("FAIL %s wait%0d_bus got=%h/%b/%h exp=%h/%b/%h", tag, k, paddr, pwrite, pwdata, addr, wr, exp_wd);
                end
            end else begin
                checks++;
                if ({psel, penable, rsp_valid} !== 3'b001) begin
                    errors++; $display("FAIL %s done_ctrl got=%b exp=001", tag, {psel, penable, rsp_valid});
                end
                checks++;
                if ({rsp_err, rsp_timeout, rsp_rdata} !== {exp_err, timed_out, exp_rd}) begin
                    errors++; $display("FAIL %s done_rsp got=%b/%b/%h exp=%b/%b/%h", tag, rsp_err, rsp_timeout, rsp_rdata, exp_err, timed_out, exp_rd);
                end
            end
        end
        @(negedge pclk);
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;

        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = $urandom;
            #1;
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL %s hold%0d_cmd_ready got=%b exp=0", tag, h, cmd_ready); end
            @(posedge pclk); #1;
            checks++;
            if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel} !== {1'b1, exp_err, timed_out, exp_rd, 1'b0}) begin
                errors++; $display("FAIL %s hold%0d_rsp got=%b/%b/%b/%h/%b exp=1/%b/%b/%h/0", tag, h, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, psel, exp_err, timed_out, exp_rd);
            end
            @(negedge pclk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge pclk); #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready} !== {3'b000, 32'h0, 1'b1}) begin
            errors++; $display("FAIL %s consume got=%b/%b/%b/%h/%b exp=0/0/0/0/1", tag, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready);
        end
        @(negedge pclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        checks++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
        end
        checks++;
        if ({paddr, pwdata, rsp_rdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data got=%h/%h/%h exp=0/0/0", paddr, pwdata, rsp_rdata);
        end
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        @(negedge pclk);
        cmd_valid = 1'b0; presetn = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_read_wait();
        run_xfer("read_wait", 1'b0, 32'h0, 32'h0, 32'h1243F6A8, 1, 1'b0, 0);
    endtask

    task automatic test_write();
        run_xfer("write", 1'b1, 32'h4, 32'hDEADBEEF, 32'hCAFEF00D, 0, 1'b0, 0);
    endtask

    task automatic test_slverr();
        run_xfer("slverr", 1'b0, 32'h10, 32'h0, 32'hA5A5A5A5, 0, 1'b1, 0);
    endtask

    task automatic test_timeout();
        run_xfer("timeout", 1'b0, 32'h20, 32'h0, 32'h55AA55AA, int'(TIMEOUT) + 4, 1'b0, 1);
        run_xfer("last_wait", 1'b0, 32'h24, 32'h0, 32'h0BADCAFE, int'(TIMEOUT) - 1, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_xfer("backpressure", 1'b1, 32'h30, 32'h13579BDF, 32'h0, 2, 1'b0, 5);
        run_xfer("after_bp", 1'b0, 32'h34, 32'h0, 32'h2468ACE0, 0, 1'b0, 0);
    endtask

    task automatic test_mid_reset();
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
        @(posedge pclk);
        @(negedge pclk);
        cmd_valid = 1'b0; pready = 1'b0;
        repeat (4) @(negedge pclk);
        presetn = 1'b0;
        @(posedge pclk); #1;
        checks++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0) begin
            errors++; $display("FAIL mid_reset got=%b exp=0000", {psel, penable, rsp_valid, cmd_ready});
        end
        @(negedge pclk);
        presetn = 1'b1;
        run_xfer("post_reset", 1'b0, 32'h44, 32'h0, 32'h0F0F1234, 1, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int nrsp = 0;
        int last_cyc = 0;
        bit prev_rv = 1'b0;
        rsp_ready = 1'b1; pslverr = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'(cyc * 4);
            pready = 1'b1; prdata = $urandom;
            @(posedge pclk); #1;
            if (rsp_valid && !prev_rv) begin
                checks++;
                if ({rsp_rdata, rsp_err} !== {prdata, 1'b0}) begin
                    errors++; $display("FAIL b2b_data%0d got=%h/%b exp=%h/0", nrsp, rsp_rdata, rsp_err, prdata);
                end
                if (nrsp > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 4) begin
                        errors++; $display("FAIL b2b_period got=%0d exp=4", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                nrsp++;
            end
            prev_rv = rsp_valid;
        end
        checks++;
        if (nrsp !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", nrsp); end
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge pclk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_xfer($sformatf("rand%0d", i), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                     int'($urandom_range(0, TIMEOUT + 3)), 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write();
        test_slverr();
        test_timeout();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
